encrypt_pipe_shift_wb: RTL and testbench
========================================

// Module: encrypt_pipe_shift_wb
// PURPOSE
//  Write-back stage of the shift pipeline, the inverse of the data-compare stage.
//  - Collapses the rotated 26-bit one-hot alpha vector back to an ASCII byte,
//    restoring upper/low case.
//  - Passes non-alpha bytes through unchanged.
//  - Buffers results in a small output FIFO with valid/ready backpressure.
//  - Tracks the character count and the active key select (k1/k2/k3) per rot_freq.
// PARAMETERS
//  DEPTH   2   output FIFO entries (power of 2, >=2)
//  CNT_W   16  width of char_cnt
// PORTS
//  clk                 in   1   clock, rising edge
//  rst                 in   1   async reset, active low
//  en                  in   1   input word present this cycle
//  mode                in   1   1 = shift mode (decode), 0 = raw pass
//  shift_en            in   1   shift cipher enabled for this word
//  is_alpha_upper_case in   1   word came from 'A'..'Z'
//  is_alpha_low_case   in   1   word came from 'a'..'z'
//  extended_shift_data in   32  rotated one-hot in [25:0], or raw byte in [7:0]
//  rot_freq            in   3   key-advance period minus one (alpha chars)
//  stall_out           out  1   FIFO full; upstream must hold (comb from count)
//  dout                out  8   head-of-FIFO ASCII byte
//  dout_valid          out  1   FIFO not empty
//  dout_ready          in   1   downstream accepts dout this cycle
//  onehot_err          out  1   1-cycle pulse: alpha word not exactly one-hot
//  char_cnt            out  CNT_W  words accepted since reset (wraps)
//  key_sel             out  2   active key: 0=k1, 1=k2, 2=k3
// BEHAVIOUR
//  Reset (rst=0, any time, mid-transfer included):
//  - FIFO emptied, dout=0, dout_valid=0, stall_out=0, onehot_err=0,
//    char_cnt=0, key_sel=0, rot counter=0.
//  - Partial state is discarded; nothing is replayed.
//  Accept: push = en & ~stall_out. When en=1 and stall_out=1 the word is
//    held by upstream (not dropped, not counted).
//  Decode of the pushed byte:
//  - mode=1, shift_en=1, upper|low: idx = position of the single set bit in
//    [25:0]; byte = idx + 65 (upper) or idx + 97 (low).
//  - Zero or multiple bits set: byte = 8'h3F ('?'), onehot_err=1 the next cycle.
//  - Upper and low both 1: treated as upper, with onehot_err=1.
//  - All other cases: byte = extended_shift_data[7:0]. Bits [31:8] are ignored.
//  Latency: a push into an empty FIFO gives dout_valid=1 on the next cycle.
//  Throughput: 1 word/cycle while dout_ready=1.
//  Pop = dout_valid & dout_ready. dout is held stable while dout_valid=1 and
//    dout_ready=0.
//  Push and pop in the same cycle:
//  - Allowed when not full; count is unchanged, order is preserved.
//  - When full, push is blocked that cycle (stall_out is registered-state based,
//    no ready->stall combinational path).
//  char_cnt: +1 per push, wraps at 2^CNT_W-1 -> 0.
//  Key rotation: a rot counter (3b) advances on each push of a decoded alpha word
//    (mode & shift_en & (upper|low)).
//  - When the counter equals rot_freq it clears to 0 and key_sel advances
//    0->1->2->0.
//  - rot_freq=0 advances key_sel on every alpha char.
//  - A rot_freq change takes effect on the next compare.
//  - key_sel updates the cycle after the push.
//  - key_sel=3 is unreachable.
//  Non-alpha words never advance the rot counter.
//  No FSM beyond the FIFO pointers, the count, and the rot counter/key_sel
//    (3-state cycle IDLE_K1 -> K2 -> K3).
// STRUCTURE
//  Package encrypt_pipe_pkg:
//  - ASCII_UPPER_BASE=8'd65, ASCII_LOW_BASE=8'd97, ALPHA_LEN=26.
//  - typedef enum logic[1:0] {KEY_K1, KEY_K2, KEY_K3} key_sel_t.
//  Sub-module encrypt_pipe_onehot_enc:
//  - Comb 26-bit one-hot -> 5-bit idx plus onehot_ok.
//  Top holds the FIFO (circular buffer, rd/wr pointers plus count), counters
//    and key_sel registers.
// TESTING
//  1. mode=1, shift_en=1, upper=1, data=1<<7, dout_ready=1
//     -> dout=8'h48 ('H'), dout_valid 1 cycle after en.
//  2. mode=1, shift_en=1, low=1, data=1<<25 -> 8'h7A ('z').
//     Same with data=32'h3 -> 8'h3F and onehot_err pulse.
//  3. shift_en=0, data[7:0]=8'h21 -> dout=8'h21.
//     char_cnt increments; key_sel unchanged.
//  4. dout_ready=0, push 3 words (DEPTH=2)
//     -> stall_out=1 after 2 pushes, 3rd held.
//     Release ready -> 3 words out in order, no loss or duplicate.
//  5. rot_freq=2, 9 alpha pushes -> key_sel sequence 0,0,0,1,1,1,2,2,2
//     then 0 after the 9th.
//  6. rst=0 asserted with 2 words buffered and key_sel=2 -> all outputs 0
//     immediately (async). First push after release decodes normally.

Source files
------------

// File: rtl/encrypt_pipe_pkg.sv
// Shared constants and types for the shift-cipher pipeline.
package encrypt_pipe_pkg;

  localparam logic [7:0] ASCII_UPPER_BASE = 8'd65;
  localparam logic [7:0] ASCII_LOW_BASE   = 8'd97;
  localparam int         ALPHA_LEN        = 26;
  localparam logic [7:0] BAD_CHAR         = 8'h3F;

  typedef enum logic [1:0] {
    KEY_K1,
    KEY_K2,
    KEY_K3
  } key_sel_t;

endpackage

// File: rtl/encrypt_pipe_onehot_enc.sv
// Collapses a 26-bit one-hot alpha vector to its index.
module encrypt_pipe_onehot_enc
  import encrypt_pipe_pkg::*;
(
  input  logic [ALPHA_LEN-1:0] i_onehot,
  output logic [4:0]           o_idx,
  output logic                 o_ok
);

  logic [ALPHA_LEN-1:0] w_low_clr;

  assign w_low_clr = i_onehot & (i_onehot - ALPHA_LEN'(1));
  assign o_ok      = (i_onehot != '0) && (w_low_clr == '0);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < ALPHA_LEN; i++) begin
      if (i_onehot[i]) o_idx = 5'(i);
    end
  end

endmodule

// File: rtl/encrypt_pipe_shift_wb.sv
// Write-back stage: one-hot to ASCII decode, output FIFO,
// character count and key rotation.
module encrypt_pipe_shift_wb
  import encrypt_pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             shift_en,
  input  logic             is_alpha_upper_case,
  input  logic             is_alpha_low_case,
  input  logic [31:0]      extended_shift_data,
  input  logic [2:0]       rot_freq,
  output logic             stall_out,
  output logic [7:0]       dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             onehot_err,
  output logic [CNT_W-1:0] char_cnt,
  output logic [1:0]       key_sel
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_rot;
  key_sel_t         r_key;

  logic             w_alpha;
  logic             w_upper;
  logic [4:0]       w_idx;
  logic             w_ok;
  logic [7:0]       w_base;
  logic [7:0]       w_byte;
  logic             w_err;
  logic             w_push;
  logic             w_pop;
  logic             w_wrap;
  logic [2:0]       w_rot_nxt;
  key_sel_t         w_key_nxt;
  logic             w_unused;

  assign w_unused = ^extended_shift_data[31:ALPHA_LEN];

  encrypt_pipe_onehot_enc u_enc (
    .i_onehot (extended_shift_data[ALPHA_LEN-1:0]),
    .o_idx    (w_idx),
    .o_ok     (w_ok)
  );

  assign w_upper = is_alpha_upper_case;
  assign w_alpha = mode & shift_en &
                   (is_alpha_upper_case | is_alpha_low_case);
  // Both case flags set decodes as upper but is still flagged.
  assign w_base  = w_upper ? ASCII_UPPER_BASE : ASCII_LOW_BASE;
  assign w_err   = w_alpha &
                   (~w_ok | (is_alpha_upper_case & is_alpha_low_case));

  always_comb begin
    w_byte = extended_shift_data[7:0];
    if (w_alpha) begin
      w_byte = w_ok ? (w_base + {3'b000, w_idx}) : BAD_CHAR;
    end
  end

  assign stall_out  = (r_count == CNT_FULL);
  assign dout_valid = (r_count != '0);
  assign dout       = dout_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign w_push     = en & ~stall_out;
  assign w_pop      = dout_valid & dout_ready;

  assign onehot_err = r_err;
  assign char_cnt   = r_cnt;
  assign key_sel    = r_key;

  assign w_wrap = (r_rot == rot_freq);

  always_comb begin
    w_rot_nxt = r_rot;
    w_key_nxt = r_key;
    if (w_push && w_alpha) begin
      if (w_wrap) begin
        w_rot_nxt = 3'd0;
        unique case (r_key)
          KEY_K1:  w_key_nxt = KEY_K2;
          KEY_K2:  w_key_nxt = KEY_K3;
          default: w_key_nxt = KEY_K1;
        endcase
      end else begin
        w_rot_nxt = r_rot + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_rot    <= 3'd0;
      r_key    <= KEY_K1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_byte;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
        r_cnt           <= r_cnt + CNT_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
      r_err <= w_push & w_err;
      r_rot <= w_rot_nxt;
      r_key <= w_key_nxt;
    end
  end

endmodule

// File: tb/tb_encrypt_pipe_shift_wb.sv
// Randomized self-checking bench for encrypt_pipe_shift_wb.
module tb_encrypt_pipe_shift_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic        shift_en = 1'b0;
  logic        up = 1'b0;
  logic        lo = 1'b0;
  logic [31:0] data = '0;
  logic [2:0]  rot_freq = 3'd0;
  logic        dout_ready = 1'b0;
  logic        stall_out;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        onehot_err;
  logic [15:0] char_cnt;
  logic [1:0]  key_sel;

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  int         m_cnt;
  int         m_alpha;
  int         m_rf;
  bit         m_err;
  bit         m_push;

  encrypt_pipe_shift_wb #(.DEPTH(2), .CNT_W(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .en                  (en),
    .mode                (mode),
    .shift_en            (shift_en),
    .is_alpha_upper_case (up),
    .is_alpha_low_case   (lo),
    .extended_shift_data (data),
    .rot_freq            (rot_freq),
    .stall_out           (stall_out),
    .dout                (dout),
    .dout_valid          (dout_valid),
    .dout_ready          (dout_ready),
    .onehot_err          (onehot_err),
    .char_cnt            (char_cnt),
    .key_sel             (key_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ref_dec(bit md, bit sh, bit u, bit l,
                                         logic [31:0] d);
    int n;
    int idx;
    n = 0;
    idx = 0;
    if (md && sh && (u || l)) begin
      for (int i = 0; i < 26; i++) if (d[i]) begin n++; idx = i; end
      if (n != 1) return {1'b1, 8'h3F};
      return {u && l, 8'(idx + (u ? 65 : 97))};
    end
    return {1'b0, d[7:0]};
  endfunction

  function automatic int exp_key();
    return (m_alpha / (m_rf + 1)) % 3;
  endfunction

  task automatic tick();
    bit push;
    bit pop;
    logic [8:0] r;
    logic [7:0] tmp;
    push = en && (q.size() < 2);
    pop  = (q.size() > 0) && dout_ready;
    r = ref_dec(mode, shift_en, up, lo, data);
    @(posedge clk);
    #1;
    if (pop) tmp = q.pop_front();
    if (push) begin
      q.push_back(r[7:0]);
      m_cnt = (m_cnt + 1) % 65536;
      if (mode && shift_en && (up || lo)) m_alpha++;
    end
    m_err = push && r[8];
    m_push = push;
  endtask

  task automatic do_reset(int rf);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rot_freq = 3'(rf);
    q.delete();
    m_cnt = 0; m_alpha = 0; m_rf = rf; m_err = 0; m_push = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_word(bit md, bit sh, bit u, bit l, logic [31:0] d);
    en = 1'b1; mode = md; shift_en = sh; up = u; lo = l; data = d;
  endtask

  task automatic test_reset();
    do_reset(0);
    total++;
    if (dout_valid !== 1'b0 || stall_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: valid=%b stall=%b want 0 0",
               dout_valid, stall_out);
    end
    total++;
    if (dout !== 8'h00 || onehot_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_data: dout=%h err=%b want 00 0",
               dout, onehot_err);
    end
    total++;
    if (char_cnt !== 16'd0 || key_sel !== 2'd0) begin
      bad++;
      $display("FAIL reset_cnt: cnt=%0d key=%0d want 0 0",
               char_cnt, key_sel);
    end
  endtask

  task automatic test_upper();
    do_reset(0);
    dout_ready = 1'b1;
    set_word(1, 1, 1, 0, 32'h1 << 7);
    tick();
    en = 1'b0;
    total++;
    if (dout_valid !== 1'b1 || dout !== 8'h48) begin
      bad++;
      $display("FAIL upper_H: valid=%b dout=%h want 1 48",
               dout_valid, dout);
    end
    tick();
    total++;
    if (dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL upper_drain: valid=%b want 0", dout_valid);
    end
  endtask

  task automatic test_low_err();
    do_reset(0);
    dout_ready = 1'b1;
    set_word(1, 1, 0, 1, 32'h1 << 25);
    tick();
    total++;
    if (dout !== 8'h7A || onehot_err !== 1'b0) begin
      bad++;
      $display("FAIL low_z: dout=%h err=%b want 7a 0", dout, onehot_err);
    end
    data = 32'h3;
    tick();
    en = 1'b0;
    total++;
    if (dout !== 8'h3F || onehot_err !== 1'b1) begin
      bad++;
      $display("FAIL multi_hot: dout=%h err=%b want 3f 1",
               dout, onehot_err);
    end
    tick();
    total++;
    if (onehot_err !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse: err=%b want 0", onehot_err);
    end
  endtask

  task automatic test_raw();
    do_reset(0);
    dout_ready = 1'b1;
    set_word(1, 0, 1, 0, 32'hABCDEF21);
    tick();
    en = 1'b0;
    total++;
    if (dout !== 8'h21 || char_cnt !== 16'd1 || key_sel !== 2'd0) begin
      bad++;
      $display("FAIL raw_pass: dout=%h cnt=%0d key=%0d want 21 1 0",
               dout, char_cnt, key_sel);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] got[$];
    do_reset(0);
    dout_ready = 1'b0;
    set_word(0, 0, 0, 0, 32'h31);
    tick();
    data = 32'h32;
    tick();
    total++;
    if (stall_out !== 1'b1) begin
      bad++;
      $display("FAIL bp_full: stall=%b want 1", stall_out);
    end
    data = 32'h33;
    tick();
    tick();
    total++;
    if (char_cnt !== 16'd2 || stall_out !== 1'b1) begin
      bad++;
      $display("FAIL bp_hold: cnt=%0d stall=%b want 2 1",
               char_cnt, stall_out);
    end
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (dout_valid) got.push_back(dout);
      tick();
      if (m_push) en = 1'b0;
    end
    total++;
    if (got.size() != 3 || got[0] !== 8'h31 || got[1] !== 8'h32 ||
        got[2] !== 8'h33) begin
      bad++;
      $display("FAIL bp_order: n=%0d want 3 words 31 32 33", got.size());
    end
    total++;
    if (char_cnt !== 16'd3) begin
      bad++;
      $display("FAIL bp_count: cnt=%0d want 3", char_cnt);
    end
  endtask

  task automatic test_rotation();
    int exp_k[9];
    exp_k = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    do_reset(2);
    dout_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      total++;
      if (key_sel !== 2'(exp_k[i])) begin
        bad++;
        $display("FAIL rot_seq[%0d]: key=%0d want %0d",
                 i, key_sel, exp_k[i]);
      end
      set_word(1, 1, i[0], !i[0], 32'h1 << (i + 3));
      tick();
    end
    en = 1'b0;
    total++;
    if (key_sel !== 2'd0) begin
      bad++;
      $display("FAIL rot_wrap: key=%0d want 0", key_sel);
    end
  endtask

  task automatic test_async_reset();
    do_reset(0);
    dout_ready = 1'b0;
    set_word(1, 1, 1, 0, 32'h1 << 2);
    tick();
    tick();
    en = 1'b0;
    total++;
    if (key_sel !== 2'd2 || stall_out !== 1'b1) begin
      bad++;
      $display("FAIL ar_setup: key=%0d stall=%b want 2 1",
               key_sel, stall_out);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (dout_valid !== 1'b0 || stall_out !== 1'b0 || dout !== 8'h00 ||
        onehot_err !== 1'b0 || char_cnt !== 16'd0 || key_sel !== 2'd0) begin
      bad++;
      $display("FAIL ar_clear: v=%b s=%b d=%h e=%b c=%0d k=%0d want all 0",
               dout_valid, stall_out, dout, onehot_err, char_cnt, key_sel);
    end
    q.delete();
    m_cnt = 0; m_alpha = 0; m_err = 0;
    @(negedge clk);
    rst = 1'b1;
    dout_ready = 1'b1;
    set_word(1, 1, 1, 0, 32'h1);
    tick();
    en = 1'b0;
    total++;
    if (dout_valid !== 1'b1 || dout !== 8'h41 || char_cnt !== 16'd1) begin
      bad++;
      $display("FAIL ar_first: v=%b d=%h c=%0d want 1 41 1",
               dout_valid, dout, char_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int s = 0; s < 4; s++) begin
      do_reset(int'($urandom_range(0, 7)));
      for (int c = 0; c < 150; c++) begin
        d = $urandom;
        if ($urandom_range(0, 9) < 8) d = (32'h1 << $urandom_range(0, 25)) |
                                          ({$urandom} & 32'hFC00_0000);
        set_word($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 1, d);
        en = $urandom_range(0, 3) != 0;
        dout_ready = $urandom_range(0, 2) != 0;
        tick();
        total++;
        if (dout_valid !== (q.size() > 0) || stall_out !== (q.size() == 2)) begin
          bad++;
          $display("FAIL rnd_flags c%0d: v=%b s=%b want %b %b", c,
                   dout_valid, stall_out, q.size() > 0, q.size() == 2);
        end
        if (q.size() > 0) begin
          total++;
          if (dout !== q[0]) begin
            bad++;
            $display("FAIL rnd_dout c%0d: dout=%h want %h", c, dout, q[0]);
          end
        end
        total++;
        if (char_cnt !== 16'(m_cnt) || key_sel !== 2'(exp_key()) ||
            onehot_err !== m_err) begin
          bad++;
          $display("FAIL rnd_state c%0d: cnt=%0d key=%0d err=%b want %0d %0d %b",
                   c, char_cnt, key_sel, onehot_err, m_cnt, exp_key(), m_err);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_upper();
    test_low_err();
    test_raw();
    test_backpressure();
    test_rotation();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
